// File: rtl/ser_demux_rx.sv
// ser_demux_rx: bit-serial receiver that steers each bit into its slot of a parallel word.
// Define SER_DEMUX_PARITY_EN to receive a trailing even-parity bit per frame.
module ser_demux_rx #(
  parameter int WIDTH     = 8,
  parameter int IDXW      = 3,
  parameter bit LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [IDXW-1:0]  idx,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             parity_err
);
  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RECV = 1'b1;
`ifdef SER_DEMUX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  logic [0:0]       state;
  logic [WIDTH-1:0] sreg, word;
  logic [IDXW-1:0]  slot;
  logic             start, take, done, load;
  // The parity slot matches no data position, so it leaves word equal to sreg.
  always_comb begin
    start = sin_valid & sof;
    take  = sin_valid & (sof | (state == RECV));
    slot  = start ? '0 : idx;
    done  = take & (32'(slot) == FL - 1);
    load  = done & (~dout_valid | dout_ready);
    word  = start ? '0 : sreg;
    for (int i = 0; i < WIDTH; i++)
      if (32'(slot) == (LSB_FIRST ? i : WIDTH - 1 - i)) word[i] = sin;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      idx        <= '0;
      sreg       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (take) begin
        state <= RECV;
        idx   <= done ? '0 : slot + 1'b1;
        sreg  <= done ? '0 : word;
      end
      if (load) dout <= word;
      dout_valid <= load | (dout_valid & ~dout_ready);
      overrun    <= (done & ~load) | (overrun & ~ovr_clr);
    end
  end
`ifdef SER_DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else if (load) parity_err <= ^sreg ^ sin;
  end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_ser_demux_rx.sv
// tb_ser_demux_rx: LSB-first and MSB-first receivers share one stimulus, checked against a frame-queue model.
module tb_ser_demux_rx;
  localparam int W  = 8;
  localparam int IW = 4;
`ifdef SER_DEMUX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif
  logic clk = 1'b0;
  logic rst_n, sin, sin_valid, sof, dout_ready, ovr_clr;
  logic [W-1:0]  dout1, dout0;
  logic [IW-1:0] idx1, idx0;
  logic dv1, dv0, ov1, ov0, pe1, pe0;
  int checks = 0, errors = 0;
  int bq[$];
  bit act, mv, mov, mpe;
  int m1, m0;

  ser_demux_rx #(.WIDTH(W), .IDXW(IW), .LSB_FIRST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dout(dout1), .dout_valid(dv1), .dout_ready(dout_ready), .idx(idx1),
    .overrun(ov1), .ovr_clr(ovr_clr), .parity_err(pe1));
  ser_demux_rx #(.WIDTH(W), .IDXW(IW), .LSB_FIRST(0)) u0 (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .dout(dout0), .dout_valid(dv0), .dout_ready(dout_ready), .idx(idx0),
    .overrun(ov0), .ovr_clr(ovr_clr), .parity_err(pe0));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    bq.delete(); act = 0; mv = 0; mov = 0; mpe = 0; m1 = 0; m0 = 0;
  endtask

  task automatic model(bit b, bit v, bit s, bit r, bit c);
    bit done = 0, ovs = 0, p = 0;
    int w1 = 0, w0 = 0;
    if (v && s) begin bq.delete(); bq.push_back(int'(b)); act = 1; end
    else if (v && act) bq.push_back(int'(b));
    if (bq.size() == FL) begin
      done = 1;
      for (int k = 0; k < W; k++) begin
        w1 += bq[k] << k;
        w0 += bq[k] << (W - 1 - k);
        p ^= bq[k][0];
      end
`ifdef SER_DEMUX_PARITY_EN
      p ^= bq[W][0];
`else
      p = 0;
`endif
      bq.delete();
    end
    if (done && mv && !r) ovs = 1;
    else if (done) begin mv = 1; m1 = w1; m0 = w0; mpe = p; end
    else if (r) mv = 0;
    mov = ovs | (mov & !c);
  endtask

  task automatic check_all();
    chk("dout_lsb", 32'(dout1), m1);
    chk("dout_msb", 32'(dout0), m0);
    chk("valid_lsb", 32'(dv1), 32'(mv));
    chk("valid_msb", 32'(dv0), 32'(mv));
    chk("idx_lsb", 32'(idx1), bq.size());
    chk("idx_msb", 32'(idx0), bq.size());
    chk("ovr_lsb", 32'(ov1), 32'(mov));
    chk("ovr_msb", 32'(ov0), 32'(mov));
    chk("perr_lsb", 32'(pe1), 32'(mpe));
    chk("perr_msb", 32'(pe0), 32'(mpe));
  endtask

  task automatic step(bit b, bit v, bit s, bit r, bit c);
    sin = b; sin_valid = v; sof = s; dout_ready = r; ovr_clr = c;
    @(posedge clk);
    model(b, v, s, r, c);
    #1 check_all();
  endtask

  // Sends v LSB-first; with parity enabled a parity bit (optionally inverted) follows.
  task automatic send_frame(logic [W-1:0] v, bit s0, bit r, int maxgap, bit pflip);
    for (int k = 0; k < FL; k++) begin
      bit b = (k < W) ? v[k] : (^v) ^ pflip;
      repeat ($urandom_range(0, maxgap)) step(1'($urandom), 0, 1'($urandom), r, 0);
      step(b, 1, s0 && k == 0, r, 0);
    end
  endtask

  initial begin
    rst_n = 0; sin = 0; sin_valid = 0; sof = 0; dout_ready = 0; ovr_clr = 0;
    model_reset();
    #2 check_all();
    @(posedge clk); #1 rst_n = 1;
    step(1, 1, 0, 1, 0);
    send_frame(8'h4D, 1, 1, 0, 0);
    chk("t1_lsb_4d", 32'(dout1), 32'h4D);
    chk("t1_msb_b2", 32'(dout0), 32'hB2);
    chk("t1_valid", 32'(dv1), 1);
    step(0, 0, 0, 1, 0);
    chk("t1_valid_1cyc", 32'(dv1), 0);
    send_frame(8'hA5, 1, 0, 0, 0);
    send_frame(8'h3C, 0, 0, 0, 0);
    chk("t3_hold_a5", 32'(dout1), 32'hA5);
    chk("t3_overrun", 32'(ov1), 1);
    step(0, 0, 0, 0, 1);
    chk("t3_ovr_clr", 32'(ov1), 0);
    step(0, 0, 0, 1, 0);
    send_frame(8'hFF, 1, 1, 3, 0);
    chk("t4_ff", 32'(dout1), 32'hFF);
    step(1, 1, 1, 1, 0);
    repeat (4) step(1'($urandom), 1, 0, 1, 0);
    send_frame(8'h81, 1, 1, 0, 0);
    chk("t5_81", 32'(dout1), 32'h81);
    chk("t5_no_ovr", 32'(ov1), 0);
`ifdef SER_DEMUX_PARITY_EN
    send_frame(8'h07, 1, 1, 0, 0);
    chk("par_ok", 32'(pe1), 0);
    send_frame(8'h07, 1, 1, 0, 1);
    chk("par_bad", 32'(pe1), 1);
`endif
    repeat (800)
      step(1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    send_frame(8'h81, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    #3 rst_n = 0;
    #1 model_reset();
    chk("rst_async_dout", 32'(dout1), 0);
    chk("rst_async_valid", 32'(dv1), 0);
    chk("rst_async_idx", 32'(idx1), 0);
    check_all();
    #2 rst_n = 1;
    @(posedge clk); #1;
    step(1, 1, 0, 1, 0);
    chk("rst_needs_sof", 32'(idx1), 0);
    send_frame(8'h3C, 1, 1, 2, 0);
    chk("post_rst_3c", 32'(dout1), 32'h3C);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
